fp_addsub_param: RTL

Parametrised, fully pipelined IEEE-754 floating-point adder/subtractor. It succeeds the fixed binary32 add/sub pipeline with these additions:
- configurable exponent and mantissa widths;
- an explicit add/sub operation select;
- complete normalisation and rounding in all five rounding modes;
- valid/ready backpressure on both sides.

It sits in the FP ALU datapath beside the other fp_pkg-based units.

---
 rtl/fp_addsub_param.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_param.sv
// Four-stage pipelined IEEE-754 adder/subtractor with parametric format,
// five rounding modes, flush-to-zero and valid/ready backpressure.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter bit FTZ   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  input  logic [2:0]             rounding_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   invalid_operation
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - 1'b1;
  localparam logic [W-1:0] QBIT = {{(EXP_W+1){1'b0}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  if (FTZ != 1'b1 || EXP_W < 4 || MAN_W < 4) begin : g_param_check
    $error("fp_addsub_param: unsupported parameterisation");
  end

  function automatic logic round_up(input logic [2:0] rm, input logic neg,
                                    input logic lsb, input logic g, input logic r, input logic s);
    case (rm)
      RTZ:     round_up = 1'b0;
      RDN:     round_up = neg & (g | r | s);
      RUP:     round_up = ~neg & (g | r | s);
      RMM:     round_up = g;
      default: round_up = g & (r | s | lsb);
    endcase
  endfunction

  function automatic logic [W-1:0] sat_value(input logic [2:0] rm, input logic neg);
    logic to_inf;
    case (rm)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = neg;
      RUP:     to_inf = ~neg;
      default: to_inf = 1'b1;
    endcase
    sat_value = to_inf ? {neg, EXP_MAX, {MAN_W{1'b0}}} : {neg, EXP_TOP, {MAN_W{1'b1}}};
  endfunction

  function automatic int lzc(input logic [AW-1:0] v);
    lzc = AW;
    for (int i = 0; i < AW; i++) if (v[i]) lzc = AW - 1 - i;
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic [2:0] rm_p1_d, rm_p1_q, rm_p2_q, rm_p3_q;
  logic spec_p1_d, spec_p1_q, spec_p2_q, spec_p3_d, spec_p3_q;
  logic sinv_p1_d, sinv_p1_q, sinv_p2_q, sinv_p3_d, sinv_p3_q;
  logic [W-1:0] sres_p1_d, sres_p1_q, sres_p2_q, sres_p3_d, sres_p3_q;
  logic sa_p1_q, sb_p1_q, sign_p2_d, sign_p2_q, sign_p3_q, sub_p2_q;
  logic [EXP_W-1:0] ea_p1_q, eb_p1_q, exp_p2_d, exp_p2_q;
  logic [MAN_W:0] ma_p1_q, mb_p1_q;
  logic [AW-1:0] ml_p2_d, ml_p2_q, ms_p2_d, ms_p2_q, mn_p3_d, mn_p3_q;
  logic signed [XW-1:0] exp_p3_d, exp_p3_q;
  logic [W-1:0] result_d, result_q;
  logic ovf_d, unf_d, inx_d, inv_d, ovf_q, unf_q, inx_q, inv_q, out_valid_q;

  // S1: classify, apply op_sub, resolve specials
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_qnan, b_qnan, a_snan, b_snan;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  always_comb begin
    sa = a[W-1];          ea = a[W-2:MAN_W]; fa = a[MAN_W-1:0];
    sb = b[W-1] ^ op_sub; eb = b[W-2:MAN_W]; fb = b[MAN_W-1:0];
    a_nan  = (ea == EXP_MAX) && (fa != '0);
    b_nan  = (eb == EXP_MAX) && (fb != '0);
    a_inf  = (ea == EXP_MAX) && (fa == '0);
    b_inf  = (eb == EXP_MAX) && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_qnan = a_nan & fa[MAN_W-1];
    b_qnan = b_nan & fb[MAN_W-1];
    a_snan = a_nan & ~fa[MAN_W-1];
    b_snan = b_nan & ~fb[MAN_W-1];
    rm_p1_d   = (rounding_mode > RMM) ? RNE : rounding_mode;
    spec_p1_d = 1'b1;
    sinv_p1_d = a_snan | b_snan;
    sres_p1_d = '0;
    if (a_qnan)              sres_p1_d = a;
    else if (b_qnan)         sres_p1_d = {sb, b[W-2:0]};
    else if (a_snan)         sres_p1_d = a | QBIT;
    else if (b_snan)         sres_p1_d = {sb, b[W-2:0]} | QBIT;
    else if (a_inf && b_inf) begin
      if (sa == sb) sres_p1_d = {sa, EXP_MAX, {MAN_W{1'b0}}};
      else begin
        sres_p1_d = QNAN;
        sinv_p1_d = 1'b1;
      end
    end
    else if (a_inf)             sres_p1_d = {sa, EXP_MAX, {MAN_W{1'b0}}};
    else if (b_inf)             sres_p1_d = {sb, EXP_MAX, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)  sres_p1_d = {(sa == sb) ? sa : (rm_p1_d == RDN), {(W-1){1'b0}}};
    else if (a_zero)            sres_p1_d = {sb, b[W-2:0]};
    else if (b_zero)            sres_p1_d = a;
    else                        spec_p1_d = 1'b0;
  end

  // S2: magnitude compare, swap, align with guard/round/sticky
  logic a_big;
  logic [EXP_W-1:0] ediff;
  logic [MAN_W:0] ms_raw;
  logic [AW-2:0] ext, shifted, lost;
  int sh;
  always_comb begin
    a_big     = {ea_p1_q, ma_p1_q} >= {eb_p1_q, mb_p1_q};
    exp_p2_d  = a_big ? ea_p1_q : eb_p1_q;
    sign_p2_d = a_big ? sa_p1_q : sb_p1_q;
    ml_p2_d   = {(a_big ? ma_p1_q : mb_p1_q), 3'b000};
    ms_raw    = a_big ? mb_p1_q : ma_p1_q;
    ediff     = exp_p2_d - (a_big ? eb_p1_q : ea_p1_q);
    sh        = (int'(ediff) > MAN_W + 3) ? MAN_W + 3 : int'(ediff);
    ext       = {ms_raw, 2'b00};
    shifted   = ext >> sh;
    lost      = ext & ~({(AW-1){1'b1}} << sh);
    ms_p2_d   = {shifted, |lost};
  end

  // S3: add/subtract, leading-zero count, normalise
  logic [AW:0] sum;
  logic signed [XW-1:0] exp_x;
  int lz;
  always_comb begin
    sum       = sub_p2_q ? ({1'b0, ml_p2_q} - {1'b0, ms_p2_q}) : ({1'b0, ml_p2_q} + {1'b0, ms_p2_q});
    exp_x     = {2'b00, exp_p2_q};
    lz        = 0;
    spec_p3_d = spec_p2_q;
    sinv_p3_d = sinv_p2_q;
    sres_p3_d = sres_p2_q;
    if (!spec_p2_q && sum == '0) begin
      spec_p3_d = 1'b1;
      sres_p3_d = {rm_p2_q == RDN, {(W-1){1'b0}}};
    end
    if (sum[AW]) begin
      mn_p3_d  = {sum[AW:2], sum[1] | sum[0]};
      exp_p3_d = exp_x + XW'(1);
    end else begin
      lz       = lzc(sum[AW-1:0]);
      mn_p3_d  = sum[AW-1:0] << lz;
      exp_p3_d = exp_x - XW'(lz);
    end
    // the aligned operand's sticky still stands for nonzero bits below R after a left shift
    mn_p3_d[0] = mn_p3_d[0] | ms_p2_q[0];
  end

  // S4: round, overflow/underflow, pack
  logic inc;
  logic [MAN_W+1:0] mr;
  logic signed [XW-1:0] er;
  logic [MAN_W-1:0] frac;
  always_comb begin
    inc  = round_up(rm_p3_q, sign_p3_q, mn_p3_q[3], mn_p3_q[2], mn_p3_q[1], mn_p3_q[0]);
    mr   = {1'b0, mn_p3_q[AW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er   = exp_p3_q + (mr[MAN_W+1] ? XW'(1) : XW'(0));
    frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    result_d = {sign_p3_q, er[EXP_W-1:0], frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = |mn_p3_q[2:0];
    inv_d = 1'b0;
    if (spec_p3_q) begin
      result_d = sres_p3_q;
      inx_d    = 1'b0;
      inv_d    = sinv_p3_q;
    end else if (!er[XW-1] && er[XW-2:0] >= {1'b0, EXP_MAX}) begin
      result_d = sat_value(rm_p3_q, sign_p3_q);
      ovf_d    = 1'b1;
      inx_d    = 1'b1;
    end else if (er[XW-1] || er == '0) begin
      result_d = {sign_p3_q, {(W-1){1'b0}}};
      unf_d    = 1'b1;
      inx_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else if (en) begin
      vld_p1_q    <= in_valid;
      vld_p2_q    <= vld_p1_q;
      vld_p3_q    <= vld_p2_q;
      out_valid_q <= vld_p3_q;
      if (vld_p3_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        inx_q    <= inx_d;
        inv_q    <= inv_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      rm_p1_q <= rm_p1_d;   spec_p1_q <= spec_p1_d; sinv_p1_q <= sinv_p1_d; sres_p1_q <= sres_p1_d;
      sa_p1_q <= sa;        sb_p1_q <= sb;          ea_p1_q <= ea;          eb_p1_q <= eb;
      ma_p1_q <= {1'b1, fa}; mb_p1_q <= {1'b1, fb};
      rm_p2_q <= rm_p1_q;   spec_p2_q <= spec_p1_q; sinv_p2_q <= sinv_p1_q; sres_p2_q <= sres_p1_q;
      sign_p2_q <= sign_p2_d; sub_p2_q <= sa_p1_q ^ sb_p1_q; exp_p2_q <= exp_p2_d;
      ml_p2_q <= ml_p2_d;   ms_p2_q <= ms_p2_d;
      rm_p3_q <= rm_p2_q;   spec_p3_q <= spec_p3_d; sinv_p3_q <= sinv_p3_d; sres_p3_q <= sres_p3_d;
      sign_p3_q <= sign_p2_q; exp_p3_q <= exp_p3_d; mn_p3_q <= mn_p3_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign result            = result_q;
  assign overflow          = ovf_q & out_valid_q;
  assign underflow         = unf_q & out_valid_q;
  assign inexact           = inx_q & out_valid_q;
  assign invalid_operation = inv_q & out_valid_q;
endmodule
